// File: rtl/wbm_cmd_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM encoding and response-entry layout.
// Entry layout grows by one timeout bit when WBM_WATCHDOG_EN is defined.
package wbm_cmd_master_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

    localparam int RESP_DAT_LSB = 0;
    localparam int RESP_DAT_W   = 32;
    localparam int RESP_WE_BIT  = 32;
    localparam int RESP_ERR_BIT = 33;
`ifdef WBM_WATCHDOG_EN
    localparam int RESP_TIMEOUT_BIT = 34;
    localparam int RESP_ENTRY_W     = 35;
`else
    localparam int RESP_ENTRY_W     = 34;
`endif

endpackage

// File: rtl/wbm_resp_fifo.sv
// Parameterised synchronous show-ahead FIFO; head_data is the oldest entry, zero when empty.
// Pointers carry one extra wrap bit so full/empty fall out of a plain compare.
module wbm_resp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset; stale contents are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_comb begin
        head_data = '0;
        if (!empty) head_data = mem[rd_ptr_reg[AW-1:0]];
    end

endmodule

// File: rtl/wbm_cmd_master.sv
// Wishbone master running one classic cycle per accepted command, completions queued in a response FIFO.
// Optional bus watchdog enabled by defining WBM_WATCHDOG_EN.
module wbm_cmd_master
    import wbm_cmd_master_pkg::*;
#(
    parameter int BUS_DATA_WIDTH  = 32,
    parameter int BUS_ADDR_WIDTH  = 32,
    parameter int RESP_FIFO_DEPTH = 4,
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [3:0]                cmd_sel_i,
    input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [BUS_DATA_WIDTH-1:0] resp_dat_o,
    output logic                      resp_we_o,
    output logic                      resp_err_o,
    output logic                      resp_timeout_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic                      wbm_we_o,
    output logic [3:0]                wbm_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i
);

    localparam int CNT_W = $clog2(RESP_FIFO_DEPTH) + 1;

    if (BUS_DATA_WIDTH != RESP_DAT_W || RESP_FIFO_DEPTH < 2 || RESP_FIFO_DEPTH > 16 ||
        (RESP_FIFO_DEPTH & (RESP_FIFO_DEPTH - 1)) != 0 || WATCHDOG_CYCLES < 2) begin : g_bad_cfg
        $error("wbm_cmd_master: unsupported parameter set");
    end

    logic [0:0]                state_reg;
    logic                      cyc_reg;
    logic                      we_reg;
    logic [3:0]                sel_reg;
    logic [BUS_ADDR_WIDTH-1:0] adr_reg;
    logic [BUS_DATA_WIDTH-1:0] dat_reg;

    logic                      accept;
    logic                      in_bus;
    logic                      timeout_hit;
    logic                      done;
    logic                      resp_push;
    logic [RESP_ENTRY_W-1:0]   resp_entry;
    logic [RESP_ENTRY_W-1:0]   fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;

    // Ready is forced low while reset is held, since state already reads IDLE then.
    assign cmd_ready_o = !wb_rst_i && (state_reg == ST_IDLE) &&
                         (fifo_count < CNT_W'(RESP_FIFO_DEPTH));
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign in_bus      = (state_reg == ST_BUS);
    assign done        = in_bus && (wbm_ack_i || wbm_err_i || timeout_hit);
    assign resp_push   = done && !fifo_full;

    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = cyc_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_sel_o = sel_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_dat_o = dat_reg;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            adr_reg   <= '0;
            dat_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg    <= cmd_we_i;
                        sel_reg   <= cmd_sel_i;
                        adr_reg   <= cmd_adr_i;
                        dat_reg   <= cmd_dat_i;
                        cyc_reg   <= 1'b1;
                        state_reg <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (done) begin
                        cyc_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef WBM_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES);

    logic [WD_W-1:0] wd_cnt_reg;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wd_cnt_reg <= '0;
        end else if (accept) begin
            wd_cnt_reg <= '0;
        end else if (in_bus) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    // A real ack/err on the expiry clock still wins over the timeout.
    assign timeout_hit = in_bus && !wbm_ack_i && !wbm_err_i &&
                         (wd_cnt_reg == WD_W'(WATCHDOG_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Error (bus or watchdog) overrides ack and zeroes the data field.
    always_comb begin
        resp_entry               = '0;
        resp_entry[RESP_WE_BIT]  = we_reg;
        resp_entry[RESP_ERR_BIT] = wbm_err_i || timeout_hit;
        if (!we_reg && !wbm_err_i && !timeout_hit)
            resp_entry[RESP_DAT_LSB +: RESP_DAT_W] = wbm_dat_i;
`ifdef WBM_WATCHDOG_EN
        resp_entry[RESP_TIMEOUT_BIT] = timeout_hit;
`endif
    end

    wbm_resp_fifo #(
        .WIDTH (RESP_ENTRY_W),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (resp_push),
        .push_data (resp_entry),
        .pop       (resp_ready_i),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign resp_valid_o = !fifo_empty;
    assign resp_dat_o   = fifo_head[RESP_DAT_LSB +: RESP_DAT_W];
    assign resp_we_o    = fifo_head[RESP_WE_BIT];
    assign resp_err_o   = fifo_head[RESP_ERR_BIT];
`ifdef WBM_WATCHDOG_EN
    assign resp_timeout_o = fifo_head[RESP_TIMEOUT_BIT];
`else
    assign resp_timeout_o = 1'b0;
`endif

endmodule

// File: doc/wbm_cmd_master.md
Name: wbm_cmd_master

Overview:
- Wishbone bus master that feeds the slave-side arbiter.
- Accepts read/write commands on a valid/ready stream (from a host transport, e.g. a serial/Ethernet command decoder) and runs one classic Wishbone cycle per command.
- Pushes each completion (read data, error flag) into a small response FIFO, which is drained by a valid/ready response stream.
- Exactly one bus transaction in flight at any time.

Parameters:
- BUS_DATA_WIDTH, 32, Wishbone data width; 32 only is supported.
- BUS_ADDR_WIDTH, 32, Wishbone and command address width.
- RESP_FIFO_DEPTH, 4, response FIFO entries; power of two, 2..16.
- WATCHDOG_CYCLES, 64, bus-cycle limit in clocks; only used with WBM_WATCHDOG_EN; must be ≥2.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_sel_i  in  4  byte selects
- cmd_adr_i  in  BUS_ADDR_WIDTH  address
- cmd_dat_i  in  BUS_DATA_WIDTH  write data
- resp_valid_o  out  1  response available (FIFO not empty)
- resp_ready_i  in  1  consumer pops when valid & ready
- resp_dat_o  out  BUS_DATA_WIDTH  read data; 0 for writes and errors
- resp_we_o  out  1  echo of command we
- resp_err_o  out  1  cycle ended by err (or watchdog)
- resp_timeout_o  out  1  cycle ended by watchdog
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte select
- wbm_adr_o  out  BUS_ADDR_WIDTH  Wishbone address
- wbm_dat_o  out  BUS_DATA_WIDTH  Wishbone write data
- wbm_dat_i  in  BUS_DATA_WIDTH  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_err_i  in  1  Wishbone error

Behaviour:
- Reset (asynchronous, wb_rst_i = 1): all wbm_* outputs are 0, cmd_ready_o = 0, FIFO is emptied, resp_valid_o = 0, resp_* data outputs are 0, state = IDLE.
- Reset asserted mid-cycle drops cyc/stb immediately; the in-flight response is discarded.
- State machine: IDLE → BUS → IDLE.
- IDLE: cmd_ready_o = 1 iff FIFO occupancy < RESP_FIFO_DEPTH. Occupancy includes an entry popped in the same cycle, so no pop/push bypass is used.
- IDLE, on accept: register we/sel/adr/dat to the wbm_* outputs and set cyc = stb = 1 on the next edge. Latency from accept to cyc is 1 clock. Go to BUS.
- BUS: cmd_ready_o = 0. All wbm_* outputs are held stable until wbm_ack_i or wbm_err_i is sampled high.
- BUS, on ack: push {dat = we ? 0 : wbm_dat_i, we, err = 0, timeout = 0}. cyc/stb/we are 0 from the next edge. Return to IDLE.
- BUS, on err: push {dat = 0, we, err = 1, timeout = 0}. The err arrives registered from the arbiter, which can be a cycle after an ack-less decode miss. Same exit as ack.
- Ack and err in the same cycle: err wins, ack ignored.
- Ack or err while in IDLE: ignored, nothing pushed.
- Back-to-back commands: a new command can be accepted in the IDLE cycle after completion. This gives at least one idle clock (cyc = 0) between cycles, which the arbiter's IDLE state requires.
- Response FIFO:
  - Synchronous, show-ahead: resp_* reflect the head entry whenever resp_valid_o = 1.
  - Pointers are log2(RESP_FIFO_DEPTH)+1 bits wide; full/empty come from the MSB compare, and wrap-around is natural binary.
  - Push and pop in the same cycle: occupancy unchanged.
  - Push is guaranteed never to hit full, because commands are only accepted when space exists.

Optional Feature:
- Macro: WBM_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entering BUS and increments each BUS clock.
  - If neither ack nor err has been seen when the counter reaches WATCHDOG_CYCLES-1, cyc/stb drop on the next edge.
  - Push {dat = 0, err = 1, timeout = 1}, then go to IDLE.
  - Ack or err in the same cycle as expiry takes priority over the timeout.
- Undefined:
  - No counter; BUS waits indefinitely.
  - resp_timeout_o is tied 0 and the FIFO entry omits the timeout bit.

Decomposition:
- Shared package: state encoding localparams (ST_IDLE = 0, ST_BUS = 1) and the response-entry field offsets/width (DAT, WE, ERR, TIMEOUT).
- One natural sub-module: wbm_resp_fifo, a parameterised synchronous show-ahead FIFO (WIDTH, DEPTH) with push/pop/full/empty/count. It is reusable elsewhere in the design.

Test Plan:
- Read, resp_ready_i = 1, adr = 0x0000_0100: cyc/stb rise 1 clock after accept; ack 3 clocks later with dat 0xDEAD_BEEF → one response {dat = 0xDEADBEEF, we = 0, err = 0}; cyc = 0 the clock after ack.
- Write to adr = 0x0000_0104, dat = 0x1234_5678, sel = 0xF: wbm_* hold stable until ack → response {dat = 0, we = 1, err = 0}.
- err asserted together with ack on a read → response err = 1, dat = 0. A stray ack injected in IDLE → no response pushed.
- resp_ready_i = 0, 5 back-to-back acked reads with DEPTH = 4: exactly 4 accepted, cmd_ready_o = 0 on the 5th until one pop. Pop order equals issue order.
- wb_rst_i pulsed asynchronously (between clock edges) mid-BUS, with 2 FIFO entries held: all wbm_* and resp_valid_o drop immediately; the next command starts cleanly.
- With WBM_WATCHDOG_EN and WATCHDOG_CYCLES = 64, no ack → cyc drops after 64 BUS clocks; response err = 1, timeout = 1. Ack on clock 64 → normal response, timeout = 0.
